// File: rtl/box_pkg.sv
// Shared encodings and default geometry for the bouncing-box motion scheduler.
package box_pkg;

  typedef enum logic [1:0] {
    OP_SET_X     = 2'd0,
    OP_SET_Y     = 2'd1,
    OP_SET_SPEED = 2'd2,
    OP_RUN_CTRL  = 2'd3
  } cmd_op_e;

  typedef enum logic [1:0] {
    ST_PAUSED     = 2'd0,
    ST_WAIT_FRAME = 2'd1,
    ST_STEP_X     = 2'd2,
    ST_STEP_Y     = 2'd3
  } state_e;

  localparam int PORCH_LEFT_DEF   = 144;
  localparam int PORCH_RIGHT_DEF  = 784;
  localparam int PORCH_TOP_DEF    = 36;
  localparam int PORCH_BOTTOM_DEF = 500;
  localparam int BOX_W_DEF        = 36;
  localparam int BOX_H_DEF        = 36;

  function automatic logic [9:0] clamp10(input logic [9:0] v, input logic [9:0] lo,
                                         input logic [9:0] hi);
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

endpackage

// File: rtl/box_motion_ctrl_if.sv
// Command port of the motion scheduler.
// Handshake: a command transfers on a rising clock edge where cmd_valid && cmd_ready;
// the master holds cmd_op/cmd_data stable while cmd_valid is high and not yet accepted.
interface box_motion_ctrl_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [9:0] cmd_data;

  modport master (output cmd_valid, output cmd_op, output cmd_data, input cmd_ready);
  modport slave  (input cmd_valid, input cmd_op, input cmd_data, output cmd_ready);
endinterface

// File: rtl/box_axis_step.sv
// One-axis step with edge bounce; used for both X and Y.
module box_axis_step (
  input  logic [9:0] pos_i,
  input  logic       dir_neg_i,
  input  logic [2:0] step_i,
  input  logic [9:0] min_i,
  input  logic [9:0] max_i,
  output logic [9:0] pos_o,
  output logic       dir_neg_o,
  output logic       bounce_o
);

  logic [10:0] sum;
  logic [10:0] lo_thresh;

  // 11-bit arithmetic so pos+step can never wrap before the bound test.
  always_comb begin
    sum       = {1'b0, pos_i} + {8'd0, step_i};
    lo_thresh = {1'b0, min_i} + {8'd0, step_i};
    pos_o     = pos_i;
    dir_neg_o = dir_neg_i;
    bounce_o  = 1'b0;
    if (!dir_neg_i) begin
      if (sum >= {1'b0, max_i}) begin
        pos_o     = max_i;
        dir_neg_o = 1'b1;
        bounce_o  = 1'b1;
      end else begin
        pos_o = sum[9:0];
      end
    end else begin
      if ({1'b0, pos_i} <= lo_thresh) begin
        pos_o     = min_i;
        dir_neg_o = 1'b0;
        bounce_o  = 1'b1;
      end else begin
        pos_o = pos_i - {7'd0, step_i};
      end
    end
  end

endmodule

// File: rtl/box_motion_ctrl.sv
// Per-frame box motion scheduler: divides frame ticks, steps X then Y with bounce,
// and accepts reconfiguration commands while idle or paused.
module box_motion_ctrl
  import box_pkg::*;
#(
  parameter int PORCH_LEFT   = PORCH_LEFT_DEF,
  parameter int PORCH_RIGHT  = PORCH_RIGHT_DEF,
  parameter int PORCH_TOP    = PORCH_TOP_DEF,
  parameter int PORCH_BOTTOM = PORCH_BOTTOM_DEF,
  parameter int BOX_W        = BOX_W_DEF,
  parameter int BOX_H        = BOX_H_DEF
) (
  input  logic               clk_25,
  input  logic               rst,
  input  logic               frame_tick,
  box_motion_ctrl_if.slave   cmd,
  output logic [9:0]         box_x,
  output logic [9:0]         box_y,
  output logic               busy,
  output logic               upd_done,
  output logic [7:0]         bounce_cnt,
  output state_e             state_dbg
);

  localparam logic [9:0] XMIN = 10'(PORCH_LEFT);
  localparam logic [9:0] XMAX = 10'(PORCH_RIGHT - BOX_W);
  localparam logic [9:0] YMIN = 10'(PORCH_TOP);
  localparam logic [9:0] YMAX = 10'(PORCH_BOTTOM - BOX_H);

  state_e     state_q, state_d;
  logic [9:0] x_q, x_d, y_q, y_d;
  logic       dir_x_q, dir_x_d, dir_y_q, dir_y_d;
  logic [2:0] step_q, step_d;
  logic [3:0] div_q, div_d;
  logic [3:0] frame_cnt_q, frame_cnt_d;
  logic [7:0] bounce_q, bounce_d;
  logic       upd_done_q;

  logic [9:0] nx, ny;
  logic       ndir_x, ndir_y, bnc_x, bnc_y;
  logic       cmd_fire;
  logic [2:0] new_step;

  box_axis_step u_step_x (
    .pos_i(x_q), .dir_neg_i(dir_x_q), .step_i(step_q), .min_i(XMIN), .max_i(XMAX),
    .pos_o(nx), .dir_neg_o(ndir_x), .bounce_o(bnc_x)
  );

  box_axis_step u_step_y (
    .pos_i(y_q), .dir_neg_i(dir_y_q), .step_i(step_q), .min_i(YMIN), .max_i(YMAX),
    .pos_o(ny), .dir_neg_o(ndir_y), .bounce_o(bnc_y)
  );

  assign cmd.cmd_ready = (state_q == ST_PAUSED) || (state_q == ST_WAIT_FRAME);
  assign cmd_fire      = cmd.cmd_valid && cmd.cmd_ready;
  assign new_step      = (cmd.cmd_data[2:0] == 3'd0) ? 3'd1 : cmd.cmd_data[2:0];

  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    y_d         = y_q;
    dir_x_d     = dir_x_q;
    dir_y_d     = dir_y_q;
    step_d      = step_q;
    div_d       = div_q;
    frame_cnt_d = frame_cnt_q;
    bounce_d    = bounce_q;

    case (state_q)
      ST_WAIT_FRAME: begin
        if (frame_tick) begin
          if (frame_cnt_q == div_q) begin
            frame_cnt_d = 4'd0;
            state_d     = ST_STEP_X;
          end else begin
            frame_cnt_d = frame_cnt_q + 4'd1;
          end
        end
      end
      ST_STEP_X: begin
        x_d     = nx;
        dir_x_d = ndir_x;
        if (bnc_x && bounce_q != 8'hFF) bounce_d = bounce_q + 8'd1;
        state_d = ST_STEP_Y;
      end
      ST_STEP_Y: begin
        y_d     = ny;
        dir_y_d = ndir_y;
        if (bnc_y && bounce_q != 8'hFF) bounce_d = bounce_q + 8'd1;
        state_d = ST_WAIT_FRAME;
      end
      default: ;
    endcase

    // Commands only fire in PAUSED/WAIT_FRAME; the tick decision above used pre-command state.
    if (cmd_fire) begin
      case (cmd_op_e'(cmd.cmd_op))
        OP_SET_X: x_d = clamp10(cmd.cmd_data, XMIN, XMAX);
        OP_SET_Y: y_d = clamp10(cmd.cmd_data, YMIN, YMAX);
        OP_SET_SPEED: begin
          step_d      = new_step;
          div_d       = cmd.cmd_data[6:3];
          frame_cnt_d = 4'd0;
        end
        OP_RUN_CTRL: begin
          frame_cnt_d = 4'd0;
          if (cmd.cmd_data[1]) bounce_d = 8'd0;
          if (!cmd.cmd_data[0])           state_d = ST_PAUSED;
          else if (state_q == ST_PAUSED)  state_d = ST_WAIT_FRAME;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_25) begin
    if (rst) begin
      state_q     <= ST_WAIT_FRAME;
      x_q         <= XMIN;
      y_q         <= YMIN;
      dir_x_q     <= 1'b0;
      dir_y_q     <= 1'b0;
      step_q      <= 3'd1;
      div_q       <= 4'd0;
      frame_cnt_q <= 4'd0;
      bounce_q    <= 8'd0;
      upd_done_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      y_q         <= y_d;
      dir_x_q     <= dir_x_d;
      dir_y_q     <= dir_y_d;
      step_q      <= step_d;
      div_q       <= div_d;
      frame_cnt_q <= frame_cnt_d;
      bounce_q    <= bounce_d;
      upd_done_q  <= (state_q == ST_STEP_Y);
    end
  end

  assign box_x      = x_q;
  assign box_y      = y_q;
  assign bounce_cnt = bounce_q;
  assign busy       = (state_q == ST_STEP_X) || (state_q == ST_STEP_Y);
  assign upd_done   = upd_done_q;
  assign state_dbg  = state_q;

endmodule
